hall_period_capture: RTL and testbench
======================================

# hall_period_capture

Upstream front end of the BLDC speed-measurement path. Synchronises the three Hall sensor inputs and validates each commutation edge against the six-step sequence. It measures the time between consecutive valid edges in prescaled ticks and reports the captured period, rotation direction, stall and error status. On every accepted edge it emits the `reset_to_zero` pulse that realigns the downstream free-running speed counter.

## Interface
- `CNT_W`, 16: width of the tick counter and `period` output.
- `PRESCALE`, 435: clocks per tick. Must be ≥ 2.

Ports:
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `enable`  in  1  measurement enable.
- `hall`  in  3  raw Hall inputs {C,B,A}, asynchronous to `clock`.
- `reset_to_zero`  out  1  one-cycle pulse on each accepted edge; drives the downstream counter clear.
- `period`  out  CNT_W  last captured edge-to-edge period in ticks.
- `period_valid`  out  1  one-cycle strobe: `period` updated.
- `direction`  out  1  1 = forward, 0 = reverse; updated on each accepted edge.
- `stalled`  out  1  level: no edge within 2^CNT_W−1 ticks.
- `hall_error`  out  1  one-cycle pulse: illegal code or skipped step.

## Operation
- **Reset values.** All outputs 0. Synchroniser flops, `prev`, prescaler and tick counter are 0. `armed` = 0.
- **Synchronisation.** `hall` passes through a 2-flop synchroniser to give `hs`. `edge` = (`hs` != `prev`). `prev` <= `hs` every cycle.
- **Forward sequence.** 001→011→010→110→100→101→001.
  - Forward step: `hs` is the successor of `prev`. Reverse step: `hs` is the predecessor of `prev`.
- **Edge classification** (only when `edge` and `enable` = 1):
  - `hs` is 000 or 111: pulse `hall_error`; `armed` <= 0; counters cleared; no capture.
  - `prev` is 000 or 111 (leaving an invalid state): accepted, but not error and no capture. Pulse `reset_to_zero`, clear counters, `armed` <= 1.
  - Valid forward/reverse step:
    - Pulse `reset_to_zero`; set `direction`.
    - If `armed` and not `stalled`: `period` <= current tick count and pulse `period_valid`.
    - Clear prescaler and tick counter; `armed` <= 1; `stalled` <= 0.
  - Valid codes that are neither successor nor predecessor (two-step skip): pulse `hall_error`; `armed` <= 0; counters cleared; no `reset_to_zero`.
- **Prescaler.** Counts 0..PRESCALE−1 and wraps. `tick` = (prescaler == PRESCALE−1).
- **Tick counter.** Increments on `tick` and saturates at 2^CNT_W−1.
  - The tick that brings it to all-ones also sets `stalled` = 1, loads `period` with all-ones, pulses `period_valid` once, and sets `armed` <= 0.
- **Stall recovery.** An accepted edge while `stalled` clears `stalled` and restarts counting, with no capture.
- **Priority.** Edge beats tick in the same cycle: the counter clears and the tick is discarded.
- **Enable low.** Prescaler and tick counter are held at 0, `armed` <= 0 and `stalled` <= 0. No pulses are generated; `period` and `direction` keep their values. `prev` still tracks `hs`.
- **Arithmetic.** Unsigned. For two accepted edges D clocks apart with no stall, `period` = floor((D−1)/PRESCALE).

## Timing
- `hall` changing before rising edge N is in `hs` after edge N+1.
- `reset_to_zero`, `period_valid`, `hall_error` and `direction` are registered outputs, valid after edge N+2. Each pulse is exactly one cycle.
- Captures are one per edge; back-to-back edges on consecutive cycles are each classified independently.
- Reset assertion mid-operation immediately forces all state and outputs to reset values. The first edge after release never captures.

## Test plan
All scenarios use CNT_W = 8, PRESCALE = 4.
- **Reset:** hold `reset` = 0 with `hall` toggling → every output is 0. Release with `hall` = 001 → no `hall_error`, no `period_valid`. First edge 000→001 gives `reset_to_zero` only.
- **Forward rotation:** steps 001,011,010,110,… spaced 40 clocks apart → first step gives no capture. Every later step gives `period` = 9, `period_valid` and `reset_to_zero` one cycle each, two cycles after the `hall` change, and `direction` = 1.
- **Reverse rotation:** 101,100,110,… spaced 20 clocks apart → `direction` = 0, `period` = 4.
- **Errors:** insert 111 mid-sequence → one `hall_error` pulse, no `period_valid`. The next valid step is re-armed only (no capture), and the step after it captures. A skip 001→010 also pulses `hall_error`.
- **Stall:** hold `hall` constant for 1100 clocks → `stalled` = 1 with `period` = 255 and one `period_valid`. The next step clears `stalled` with no capture.
- **Enable and reset:** drop `enable` mid-period → no pulses, `period` held. Assert `reset` mid-period → immediate zeros and no spurious capture after release.

Source files
------------

// File: rtl/hall_period_capture.sv
// hall_period_capture
//
// Front end of the BLDC speed-measurement path. The raw Hall inputs are
// synchronised, and each change of the synchronised code is checked against
// the six-step commutation sequence. The time between accepted edges is
// measured in prescaled ticks, and captured as the rotation period.
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous, active-low reset
//   enable         measurement enable
//   hall[2:0]      raw Hall inputs {C,B,A}, asynchronous to clock
//   reset_to_zero  one-cycle pulse on every accepted edge (downstream counter clear)
//   period         last captured edge-to-edge period in ticks
//   period_valid   one-cycle strobe when period is updated
//   direction      1 = forward, 0 = reverse
//   stalled        level: no edge within 2^CNT_W-1 ticks
//   hall_error     one-cycle pulse on an illegal code or a skipped step
module hall_period_capture #(
  parameter int CNT_W    = 16,
  parameter int PRESCALE = 435
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       hall,
  output logic             reset_to_zero,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             direction,
  output logic             stalled,
  output logic             hall_error
);

  localparam int                PS_W     = $clog2(PRESCALE);
  localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  // Count value one below saturation: the tick leaving this value stalls.
  localparam logic [CNT_W-1:0]  CNT_NEAR = {{(CNT_W-1){1'b1}}, 1'b0};

  // Forward order is 001 -> 011 -> 010 -> 110 -> 100 -> 101 -> 001.
  // Invalid codes map to 000, which never equals a valid synchronised code.
  function automatic logic [2:0] succ(input logic [2:0] c);
    logic [2:0] r;
    case (c)
      3'b001:  r = 3'b011;
      3'b011:  r = 3'b010;
      3'b010:  r = 3'b110;
      3'b110:  r = 3'b100;
      3'b100:  r = 3'b101;
      3'b101:  r = 3'b001;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] pred(input logic [2:0] c);
    logic [2:0] r;
    case (c)
      3'b001:  r = 3'b101;
      3'b011:  r = 3'b001;
      3'b010:  r = 3'b011;
      3'b110:  r = 3'b010;
      3'b100:  r = 3'b110;
      3'b101:  r = 3'b100;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  // Synchroniser and previous-code register
  logic [2:0] sync1_reg;
  logic [2:0] hs_reg;
  logic [2:0] prev_reg;

  // Measurement state
  logic [PS_W-1:0]  ps_reg,  ps_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             armed_reg, armed_next;

  // Next values of the registered outputs
  logic [CNT_W-1:0] period_next;
  logic             rtz_next;
  logic             pv_next;
  logic             dir_next;
  logic             stalled_next;
  logic             err_next;

  logic edge_det;
  logic tick;
  logic hs_invalid;
  logic prev_invalid;
  logic is_fwd;
  logic is_rev;

  always_comb begin
    edge_det     = (hs_reg != prev_reg);
    tick         = (ps_reg == PS_LAST);
    hs_invalid   = (hs_reg == 3'b000) || (hs_reg == 3'b111);
    prev_invalid = (prev_reg == 3'b000) || (prev_reg == 3'b111);
    is_fwd       = (hs_reg == succ(prev_reg));
    is_rev       = (hs_reg == pred(prev_reg));
  end

  always_comb begin
    ps_next      = ps_reg;
    cnt_next     = cnt_reg;
    armed_next   = armed_reg;
    period_next  = period;
    dir_next     = direction;
    stalled_next = stalled;
    rtz_next     = 1'b0;
    pv_next      = 1'b0;
    err_next     = 1'b0;

    if (!enable) begin
      // Measurement idle: counters parked, nothing armed, no pulses.
      ps_next      = '0;
      cnt_next     = '0;
      armed_next   = 1'b0;
      stalled_next = 1'b0;
    end else if (edge_det) begin
      // Any classified edge restarts the measurement; a tick in the same
      // cycle is dropped on purpose.
      ps_next  = '0;
      cnt_next = '0;
      if (hs_invalid) begin
        err_next   = 1'b1;
        armed_next = 1'b0;
      end else if (prev_invalid) begin
        // Recovering from an invalid code: realign, but the interval is
        // meaningless so nothing is captured.
        rtz_next     = 1'b1;
        armed_next   = 1'b1;
        stalled_next = 1'b0;
      end else if (is_fwd || is_rev) begin
        rtz_next = 1'b1;
        dir_next = is_fwd;
        if (armed_reg && !stalled) begin
          period_next = cnt_reg;
          pv_next     = 1'b1;
        end
        armed_next   = 1'b1;
        stalled_next = 1'b0;
      end else begin
        // Two-step skip: a commutation was missed.
        err_next   = 1'b1;
        armed_next = 1'b0;
      end
    end else begin
      ps_next = tick ? '0 : ps_reg + 1'b1;
      if (tick && (cnt_reg != CNT_MAX)) begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CNT_NEAR) begin
          // Saturation reached: report an all-ones period once and stop
          // trusting the interval until the next accepted edge.
          stalled_next = 1'b1;
          period_next  = CNT_MAX;
          pv_next      = 1'b1;
          armed_next   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_reg     <= '0;
      hs_reg        <= '0;
      prev_reg      <= '0;
      ps_reg        <= '0;
      cnt_reg       <= '0;
      armed_reg     <= 1'b0;
      period        <= '0;
      reset_to_zero <= 1'b0;
      period_valid  <= 1'b0;
      direction     <= 1'b0;
      stalled       <= 1'b0;
      hall_error    <= 1'b0;
    end else begin
      sync1_reg     <= hall;
      hs_reg        <= sync1_reg;
      prev_reg      <= hs_reg;
      ps_reg        <= ps_next;
      cnt_reg       <= cnt_next;
      armed_reg     <= armed_next;
      period        <= period_next;
      reset_to_zero <= rtz_next;
      period_valid  <= pv_next;
      direction     <= dir_next;
      stalled       <= stalled_next;
      hall_error    <= err_next;
    end
  end

endmodule

// File: tb/tb_hall_period_capture.sv
// Testbench for hall_period_capture (CNT_W = 8, PRESCALE = 4).
// Directed scenarios followed by a randomized Hall walk, checked against a
// reference model that reasons about hall-change times and the commutation
// sequence position.
module tb_hall_period_capture;

  localparam int CNT_W    = 8;
  localparam int PRESCALE = 4;
  localparam int STALL_IDX = 2 + PRESCALE * ((1 << CNT_W) - 1);

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic [2:0]       hall = 3'b000;
  logic             reset_to_zero;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             direction;
  logic             stalled;
  logic             hall_error;

  hall_period_capture #(.CNT_W(CNT_W), .PRESCALE(PRESCALE)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .hall          (hall),
    .reset_to_zero (reset_to_zero),
    .period        (period),
    .period_valid  (period_valid),
    .direction     (direction),
    .stalled       (stalled),
    .hall_error    (hall_error)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  int seq [6] = '{1, 3, 2, 6, 4, 5};

  // Reference model state
  logic [2:0]       m_prev;
  bit               m_armed, m_stalled, m_en, m_dir;
  logic [CNT_W-1:0] m_period;
  int               m_last;

  // Expectations for the step being observed
  bit               exp_rtz, exp_pv, exp_err;
  logic [CNT_W-1:0] exp_period;
  int               stall_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    check(tag, {19'b0, reset_to_zero, period_valid, hall_error, direction, stalled, period}, 32'd0);
  endtask

  function automatic int pos(input logic [2:0] c);
    for (int i = 0; i < 6; i++) if (seq[i] == int'(c)) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_prev = 3'b000; m_armed = 0; m_stalled = 0; m_dir = 0; m_period = '0; m_last = cyc;
  endtask

  task automatic model_change(input logic [2:0] h, input int gap);
    int pp, hp;
    exp_rtz = 0; exp_pv = 0; exp_err = 0; stall_idx = -1; exp_period = m_period;
    if (m_en) begin
      pp = pos(m_prev);
      hp = pos(h);
      if (hp < 0) begin
        exp_err = 1; m_armed = 0;
      end else if (pp < 0) begin
        exp_rtz = 1; m_armed = 1; m_stalled = 0; m_last = cyc;
      end else if (hp == (pp + 1) % 6 || hp == (pp + 5) % 6) begin
        exp_rtz = 1;
        m_dir = (hp == (pp + 1) % 6);
        if (m_armed && !m_stalled) begin
          exp_pv = 1;
          m_period = CNT_W'((cyc - m_last - 1) / PRESCALE);
          exp_period = m_period;
        end
        m_armed = 1; m_stalled = 0; m_last = cyc;
      end else begin
        exp_err = 1; m_armed = 0;
      end
      if (gap > STALL_IDX) begin
        stall_idx = STALL_IDX; m_stalled = 1; m_armed = 0; m_period = '1;
      end
    end
    m_prev = h;
  endtask

  // Runs gap clock cycles after a hall change; results of the change are due
  // on the third rising edge (index 2).
  task automatic observe(input int gap);
    int extra = 0;
    for (int i = 0; i < gap; i++) begin
      @(posedge clock); #1; cyc++;
      if (i == 2) begin
        check("reset_to_zero", 32'(reset_to_zero), 32'(exp_rtz));
        check("period_valid", 32'(period_valid), 32'(exp_pv));
        check("hall_error", 32'(hall_error), 32'(exp_err));
        if (exp_pv) check("captured period", 32'(period), 32'(exp_period));
      end else if (i == stall_idx) begin
        check("stall strobe", 32'(period_valid), 32'd1);
        check("stall period", 32'(period), 32'((1 << CNT_W) - 1));
        check("stall level", 32'(stalled), 32'd1);
      end else if (reset_to_zero || period_valid || hall_error) begin
        extra++;
      end
    end
    check("stray pulses", 32'(extra), 32'd0);
    check("period held", 32'(period), 32'(m_period));
    check("direction", 32'(direction), 32'(m_dir));
    check("stalled", 32'(stalled), 32'(m_stalled));
    @(negedge clock);
  endtask

  task automatic step(input logic [2:0] h, input int gap);
    hall = h;
    model_change(h, gap);
    observe(gap);
  endtask

  initial begin
    int fwd [6] = '{3, 2, 6, 4, 5, 1};
    int rev [6] = '{5, 4, 6, 2, 3, 1};
    int pp, r, gap;
    logic [2:0] h;

    // Reset held with hall toggling: every output stays zero.
    reset = 0; enable = 1; m_en = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      check_zero("in reset");
      hall = 3'($urandom_range(0, 7));
    end

    // Release with hall = 001: first edge 000->001 only realigns.
    @(negedge clock);
    model_reset();
    reset = 1;
    step(3'b001, 40);

    // Forward rotation, 40 clocks per step.
    for (int i = 0; i < 6; i++) step(3'(fwd[i]), 40);

    // Reverse rotation, 20 clocks per step.
    for (int i = 0; i < 6; i++) step(3'(rev[i]), 20);

    // Illegal code, re-arm, capture, then a two-step skip.
    step(3'b111, 20);
    step(3'b011, 20);
    step(3'b010, 20);
    step(3'b011, 20);
    step(3'b001, 20);
    step(3'b010, 20);

    // Stall, recovery without capture, then normal capture.
    step(3'b110, 1100);
    step(3'b100, 20);
    step(3'b101, 20);

    // Enable dropped mid-period; hall still moves but nothing is reported.
    step(3'b001, 12);
    enable = 0; m_en = 0; m_armed = 0; m_stalled = 0;
    step(3'b011, 15);
    step(3'b010, 15);
    enable = 1; m_en = 1;
    step(3'b110, 30);
    step(3'b100, 30);

    // Reset asserted mid-period.
    step(3'b101, 10);
    reset = 0;
    #1 check_zero("async reset");
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check_zero("reset held");
    end
    model_reset();
    reset = 1;
    step(3'b101, 40);
    step(3'b001, 20);

    // Randomized walk.
    for (int n = 0; n < 40; n++) begin
      pp = pos(m_prev);
      if (pp < 0) begin
        h = 3'(seq[$urandom_range(0, 5)]);
      end else begin
        r = int'($urandom_range(0, 9));
        if (r < 6)       h = 3'(seq[(pp + 1) % 6]);
        else if (r < 8)  h = 3'(seq[(pp + 5) % 6]);
        else if (r == 8) h = 3'(seq[(pp + int'($urandom_range(2, 4))) % 6]);
        else             h = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'b000;
      end
      gap = int'($urandom_range(3, 200));
      step(h, gap);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
